// File: rtl/opsel_pkg.sv
// Shared definitions for the operand select pipeline: source tags and the
// skid-buffer occupancy encoding {mainValid, skidValid}.
package opsel_pkg;

    localparam int SRC_W = 2;

    localparam logic [SRC_W-1:0] SRC_BANK = 2'b00;
    localparam logic [SRC_W-1:0] SRC_R    = 2'b01;
    localparam logic [SRC_W-1:0] SRC_IMM  = 2'b10;
    localparam logic [SRC_W-1:0] SRC_OOR  = 2'b11;

    // Encoding bits are {mainValid, skidValid}; 2'b01 is unreachable.
    typedef enum logic [1:0] {
        BUF_EMPTY = 2'b00,
        BUF_BUSY  = 2'b10,
        BUF_FULL  = 2'b11
    } buf_state_e;

endpackage

// File: rtl/opsel_skid_buf.sv
// Generic 2-entry valid/ready skid buffer: main register drives the outputs,
// skid register catches the one request accepted while the consumer stalls.
module opsel_skid_buf
    import opsel_pkg::*;
#(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);

    buf_state_e   state_q;
    logic [W-1:0] main_q;
    logic [W-1:0] skid_q;
    logic         accept;
    logic         transfer;

    // Ready is decoded from registered state only, so outReady never
    // reaches inReady combinationally.
    assign in_ready  = (state_q != BUF_FULL);
    assign out_valid = (state_q != BUF_EMPTY);
    assign out_data  = main_q;

    assign accept   = in_valid && in_ready;
    assign transfer = out_valid && out_ready;

    // NOTE: the two payload registers are plain flops, not a memory array, so
    // resetting them is cheap and makes outData read 0 straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BUF_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            case (state_q)
                BUF_EMPTY: begin
                    if (accept) begin
                        main_q  <= in_data;
                        state_q <= BUF_BUSY;
                    end
                end
                BUF_BUSY: begin
                    if (accept && transfer) begin
                        main_q <= in_data;
                    end else if (accept) begin
                        skid_q  <= in_data;
                        state_q <= BUF_FULL;
                    end else if (transfer) begin
                        state_q <= BUF_EMPTY;
                    end
                end
                BUF_FULL: begin
                    if (transfer) begin
                        main_q  <= skid_q;
                        state_q <= BUF_BUSY;
                    end
                end
                default: state_q <= BUF_EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/operand_select_pipe.sv
// Registered operand select: imm > R > bank, result held in a skid buffer.
// Optional stall counter enabled by defining OPSEL_STALL_CNT_EN.
module operand_select_pipe
    import opsel_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8,
    parameter int SEL_W    = $clog2(NUM_REGS)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REGS*DATA_W-1:0] regBank,
    input  logic [DATA_W-1:0]          regR,
    input  logic [DATA_W-1:0]          imm,
    input  logic [SEL_W-1:0]           regSelect,
    input  logic                       regRSelect,
    input  logic                       immSelect,
    input  logic                       inValid,
    output logic                       inReady,
    output logic [DATA_W-1:0]          outData,
    output logic [1:0]                 outSrc,
    output logic                       outErr,
`ifdef OPSEL_STALL_CNT_EN
    input  logic                       stallClr,
    output logic [15:0]                stallCnt,
`endif
    output logic                       outValid,
    input  logic                       outReady
);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [SRC_W-1:0]  src;
        logic              err;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    entry_t            in_entry;
    entry_t            out_entry;
    logic [DATA_W-1:0] bank_word;
    logic              in_range;

    // NUM_REGS need not be a power of two, so indices at or above it are
    // flagged rather than wrapped into the bank.
    assign in_range = ({1'b0, regSelect} < NUM_REGS[SEL_W:0]);

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        bank_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (regSelect == SEL_W'(i)) begin
                bank_word = regBank[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        in_entry = '0;
        if (immSelect) begin
            in_entry.data = imm;
            in_entry.src  = SRC_IMM;
        end else if (regRSelect) begin
            in_entry.data = regR;
            in_entry.src  = SRC_R;
        end else if (in_range) begin
            in_entry.data = bank_word;
            in_entry.src  = SRC_BANK;
        end else begin
            in_entry.src  = SRC_OOR;
            in_entry.err  = 1'b1;
        end
    end

    opsel_skid_buf #(
        .W(ENTRY_W)
    ) u_skid_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_entry),
        .in_valid (inValid),
        .in_ready (inReady),
        .out_data (out_entry),
        .out_valid(outValid),
        .out_ready(outReady)
    );

    assign outData = out_entry.data;
    assign outSrc  = out_entry.src;
    assign outErr  = out_entry.err;

`ifdef OPSEL_STALL_CNT_EN
    logic stall;
    assign stall = outValid && !outReady;

    // Clear takes priority over a coincident stall; the count saturates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stallCnt <= '0;
        end else if (stallClr) begin
            stallCnt <= '0;
        end else if (stall && (stallCnt != 16'hFFFF)) begin
            stallCnt <= stallCnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_operand_select_pipe.sv
// Directed bench for operand_select_pipe (NUM_REGS=6 to exercise out-of-range).
module tb_operand_select_pipe;

    localparam int DATA_W   = 16;
    localparam int NUM_REGS = 6;
    localparam int SEL_W    = $clog2(NUM_REGS);

    logic                       clk;
    logic                       rst_n;
    logic [NUM_REGS*DATA_W-1:0] regBank;
    logic [DATA_W-1:0]          regR;
    logic [DATA_W-1:0]          imm;
    logic [SEL_W-1:0]           regSelect;
    logic                       regRSelect;
    logic                       immSelect;
    logic                       inValid;
    logic                       inReady;
    logic [DATA_W-1:0]          outData;
    logic [1:0]                 outSrc;
    logic                       outErr;
    logic                       outValid;
    logic                       outReady;
`ifdef OPSEL_STALL_CNT_EN
    logic                       stallClr;
    logic [15:0]                stallCnt;
`endif

    int checks;
    int errors;

    logic [DATA_W-1:0] bank_vals [NUM_REGS];

    operand_select_pipe #(
        .DATA_W  (DATA_W),
        .NUM_REGS(NUM_REGS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .regBank   (regBank),
        .regR      (regR),
        .imm       (imm),
        .regSelect (regSelect),
        .regRSelect(regRSelect),
        .immSelect (immSelect),
        .inValid   (inValid),
        .inReady   (inReady),
        .outData   (outData),
        .outSrc    (outSrc),
        .outErr    (outErr),
`ifdef OPSEL_STALL_CNT_EN
        .stallClr  (stallClr),
        .stallCnt  (stallCnt),
`endif
        .outValid  (outValid),
        .outReady  (outReady)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic v, input logic im, input logic rr, input logic [SEL_W-1:0] sel);
        inValid    = v;
        immSelect  = im;
        regRSelect = rr;
        regSelect  = sel;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [15:0] d,
                             input logic [1:0] s, input logic e);
        check({tag, ".valid"}, 32'(outValid), 32'(v));
        check({tag, ".data"},  32'(outData),  32'(d));
        check({tag, ".src"},   32'(outSrc),   32'(s));
        check({tag, ".err"},   32'(outErr),   32'(e));
    endtask

    initial begin
        logic [15:0] exp_d;
        logic [1:0]  exp_s;

        checks = 0;
        errors = 0;
        bank_vals = '{16'h00A0, 16'h0011, 16'h0022, 16'h0033, 16'h0044, 16'h0055};
        for (int i = 0; i < NUM_REGS; i++) regBank[i*DATA_W +: DATA_W] = bank_vals[i];
        regR     = 16'h5555;
        imm      = 16'hAAAA;
        outReady = 1'b0;
        rst_n    = 1'b0;
`ifdef OPSEL_STALL_CNT_EN
        stallClr = 1'b0;
`endif
        req(1'b0, 1'b0, 1'b0, '0);

        // Reset state
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        check_out("reset", 1'b0, 16'h0000, 2'b00, 1'b0);
        check("reset.inReady", 32'(inReady), 32'd1);
`ifdef OPSEL_STALL_CNT_EN
        check("reset.stallCnt", 32'(stallCnt), 32'd0);
`endif

        // Priority: imm > R > bank
        outReady = 1'b1;
        req(1'b1, 1'b1, 1'b1, 3'd3);
        tick();
        check_out("prio_imm", 1'b1, 16'hAAAA, 2'b10, 1'b0);
        req(1'b1, 1'b0, 1'b1, 3'd3);
        tick();
        check_out("prio_r", 1'b1, 16'h5555, 2'b01, 1'b0);
        req(1'b1, 1'b0, 1'b0, 3'd3);
        tick();
        check_out("prio_bank", 1'b1, 16'h0033, 2'b00, 1'b0);
        req(1'b0, 1'b0, 1'b0, '0);
        tick();
        check("prio_drain.valid", 32'(outValid), 32'd0);

        // Streaming: bank 0..5, then R, then imm, one result per cycle
        for (int k = 0; k < 8; k++) begin
            if (k < NUM_REGS) begin
                req(1'b1, 1'b0, 1'b0, SEL_W'(k));
                exp_d = bank_vals[k];
                exp_s = 2'b00;
            end else if (k == NUM_REGS) begin
                req(1'b1, 1'b0, 1'b1, '0);
                exp_d = 16'h5555;
                exp_s = 2'b01;
            end else begin
                req(1'b1, 1'b1, 1'b0, '0);
                exp_d = 16'hAAAA;
                exp_s = 2'b10;
            end
            tick();
            check_out($sformatf("stream%0d", k), 1'b1, exp_d, exp_s, 1'b0);
            check($sformatf("stream%0d.inReady", k), 32'(inReady), 32'd1);
        end
        req(1'b0, 1'b0, 1'b0, '0);
        tick();
        check("stream_drain.valid", 32'(outValid), 32'd0);

        // Backpressure: two accepts fill main and skid, then inReady drops
        outReady = 1'b0;
        req(1'b1, 1'b0, 1'b0, 3'd1);
        tick();
        check_out("bp_first", 1'b1, 16'h0011, 2'b00, 1'b0);
        check("bp_first.inReady", 32'(inReady), 32'd1);
        req(1'b1, 1'b0, 1'b0, 3'd2);
        tick();
        check_out("bp_full", 1'b1, 16'h0011, 2'b00, 1'b0);
        check("bp_full.inReady", 32'(inReady), 32'd0);
        req(1'b1, 1'b0, 1'b0, 3'd4);
        tick();
        tick();
        check_out("bp_hold", 1'b1, 16'h0011, 2'b00, 1'b0);
        check("bp_hold.inReady", 32'(inReady), 32'd0);
        req(1'b0, 1'b0, 1'b0, '0);
        outReady = 1'b1;
        tick();
        check_out("bp_drain1", 1'b1, 16'h0022, 2'b00, 1'b0);
        check("bp_drain1.inReady", 32'(inReady), 32'd1);
        tick();
        check("bp_drain2.valid", 32'(outValid), 32'd0);

        // Out-of-range: index NUM_REGS and beyond
        req(1'b1, 1'b0, 1'b0, 3'd7);
        tick();
        check_out("oor7", 1'b1, 16'h0000, 2'b11, 1'b1);
        req(1'b1, 1'b0, 1'b0, 3'd6);
        tick();
        check_out("oor6", 1'b1, 16'h0000, 2'b11, 1'b1);
        req(1'b1, 1'b0, 1'b0, 3'd5);
        tick();
        check_out("oor_clear", 1'b1, 16'h0055, 2'b00, 1'b0);
        req(1'b0, 1'b0, 1'b0, '0);
        tick();

        // Reset while FULL (main holds an error entry)
        outReady = 1'b0;
        req(1'b1, 1'b0, 1'b0, 3'd7);
        tick();
        req(1'b1, 1'b0, 1'b0, 3'd2);
        tick();
        req(1'b0, 1'b0, 1'b0, '0);
        check_out("pre_rst", 1'b1, 16'h0000, 2'b11, 1'b1);
        check("pre_rst.inReady", 32'(inReady), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("mid_rst", 1'b0, 16'h0000, 2'b00, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst.inReady", 32'(inReady), 32'd1);
        check("post_rst.valid", 32'(outValid), 32'd0);
        outReady = 1'b1;
        req(1'b1, 1'b0, 1'b0, 3'd4);
        tick();
        check_out("post_rst_op", 1'b1, 16'h0044, 2'b00, 1'b0);
        req(1'b0, 1'b0, 1'b0, '0);
        tick();
        check("post_rst_drain.valid", 32'(outValid), 32'd0);

`ifdef OPSEL_STALL_CNT_EN
        // Stall counter: clear beats a coincident stall, counts, saturates
        outReady = 1'b0;
        req(1'b1, 1'b0, 1'b0, 3'd1);
        tick();
        req(1'b0, 1'b0, 1'b0, '0);
        stallClr = 1'b1;
        tick();
        stallClr = 1'b0;
        check("stall_clr_wins", 32'(stallCnt), 32'd0);
        repeat (10) tick();
        check("stall_count10", 32'(stallCnt), 32'd10);
        repeat (70000) tick();
        check("stall_sat", 32'(stallCnt), 32'hFFFF);
        check("stall_hold_data", 32'(outData), 32'h0011);
        stallClr = 1'b1;
        tick();
        stallClr = 1'b0;
        check("stall_clr", 32'(stallCnt), 32'd0);
        outReady = 1'b1;
        tick();
        check("stall_after_drain", 32'(stallCnt), 32'd0);
        check("stall_drain.valid", 32'(outValid), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
